// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper command path: command word field layout
// and the sequencer state encoding.
package stepper_pkg;

  localparam int TARGET_MSB = 20;
  localparam int DWELL_LSB  = 21;
  localparam int DWELL_MSB  = 30;
  localparam int DWELL_W    = DWELL_MSB - DWELL_LSB + 1;
  localparam int CMD_W      = 32;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_DWELL      = 3'd4
  } seq_state_t;

  function automatic logic [DWELL_W-1:0] cmd_dwell(input logic [CMD_W-1:0] cmd);
    return cmd[DWELL_MSB:DWELL_LSB];
  endfunction

endpackage

// File: rtl/stepper_cmd_sequencer_if.sv
// Signal bundle between the processor/driver side and the command sequencer.
interface stepper_cmd_sequencer_if #(
  parameter int DEPTH = 4
);
  import stepper_pkg::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  // Handshakes: wr_en is a push qualified by !full in the same cycle (a write
  // while full is dropped and flagged in overflow); new_data is a one-cycle
  // issue strobe with no back-pressure, qualified by motor_busy being low
  // the cycle before; cmd_done is a one-cycle completion pulse.
  logic             wr_en;
  logic [CMD_W-1:0] wr_data;
  logic             clr_ovf;
  logic             motor_busy;
  logic [CMD_W-1:0] data_out;
  logic             new_data;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic             seq_busy;
  logic             cmd_done;

  modport master (
    output wr_en, wr_data, clr_ovf, motor_busy,
    input  data_out, new_data, full, empty, level, overflow, seq_busy, cmd_done
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf, motor_busy,
    output data_out, new_data, full, empty, level, overflow, seq_busy, cmd_done
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; read data is registered on pop
// and holds its value until the next pop.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pop_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        pop_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/stepper_cmd_sequencer.sv
// Queues position commands and issues them to the stepper driver one at a
// time, waiting for each move and its dwell to finish before the next.
module stepper_cmd_sequencer
  import stepper_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int CYCLES_PER_MS = 100000,
  parameter int START_TIMEOUT = 8
) (
  input  logic                    CLK100MHZ,
  input  logic                    CPU_RESETN,
  stepper_cmd_sequencer_if.slave  bus,
  output seq_state_t              state_dbg
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int TO_W  = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam int PRE_W = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(START_TIMEOUT - 1);
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(CYCLES_PER_MS - 1);
  localparam logic [DWELL_W-1:0] MS_ONE   = DWELL_W'(1);

  seq_state_t         state_q, state_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [DWELL_W-1:0] ms_q, ms_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               pop;
  logic               done;
  logic               new_data_q;
  logic               overflow_q;

  logic [CMD_W-1:0]   head_q;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LVL_W-1:0]   fifo_level;

  sync_fifo #(
    .DATA_W (CMD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (CLK100MHZ),
    .rst_n     (CPU_RESETN),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (pop),
    .pop_data  (head_q),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state_q    <= ST_IDLE;
      to_q       <= '0;
      ms_q       <= '0;
      pre_q      <= '0;
      new_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_q       <= to_d;
      ms_q       <= ms_d;
      pre_q      <= pre_d;
      new_data_q <= pop;
    end
  end

  // The last millisecond finishes on the prescaler wrap itself, so a dwell
  // of N ms completes exactly N*CYCLES_PER_MS cycles after the move ends.
  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    ms_d    = ms_q;
    pre_d   = pre_q;
    pop     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !bus.motor_busy) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        to_d    = '0;
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (bus.motor_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (to_q == TO_LAST) begin
          // Motor never started: target already reached, go straight to dwell.
          state_d = ST_DWELL;
          ms_d    = cmd_dwell(head_q);
          pre_d   = '0;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.motor_busy) begin
          state_d = ST_DWELL;
          ms_d    = cmd_dwell(head_q);
          pre_d   = '0;
        end
      end
      ST_DWELL: begin
        if (ms_q == '0 || (ms_q == MS_ONE && pre_q == PRE_LAST)) begin
          done    = 1'b1;
          state_d = ST_IDLE;
          ms_d    = '0;
          pre_d   = '0;
        end else if (pre_q == PRE_LAST) begin
          pre_d = '0;
          ms_d  = ms_q - 1'b1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Set wins over clear when both happen in the same cycle.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      overflow_q <= 1'b0;
    end else if (bus.wr_en && fifo_full) begin
      overflow_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  // Strobes are masked while reset is held so nothing reaches the driver.
  assign bus.new_data = new_data_q && CPU_RESETN;
  assign bus.cmd_done = done && CPU_RESETN;
  assign bus.data_out = head_q;
  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.level    = fifo_level;
  assign bus.overflow = overflow_q;
  assign bus.seq_busy = (state_q != ST_IDLE);
  assign state_dbg    = state_q;

  a_new_data_single: assert property (@(posedge CLK100MHZ) disable iff (!CPU_RESETN)
    new_data_q |=> !new_data_q);

  a_issue_follows_pop: assert property (@(posedge CLK100MHZ) disable iff (!CPU_RESETN)
    new_data_q |-> state_q == ST_ISSUE);

endmodule

// File: tb/tb_stepper_cmd_sequencer.sv
// Directed bench for stepper_cmd_sequencer with a behavioural motor model
// and an issue scoreboard.
module tb_stepper_cmd_sequencer;
  import stepper_pkg::*;

  localparam int DEPTH = 4;
  localparam int CPM   = 10;
  localparam int STO   = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  stepper_cmd_sequencer_if #(.DEPTH(DEPTH)) bus();
  seq_state_t state_dbg;

  logic model_busy = 1'b0;
  logic hold_busy  = 1'b0;
  assign bus.motor_busy = model_busy | hold_busy;

  stepper_cmd_sequencer #(
    .DEPTH         (DEPTH),
    .CYCLES_PER_MS (CPM),
    .START_TIMEOUT (STO)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .bus        (bus.slave),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  int issue_cnt = 0, done_cnt = 0;
  int last_high = -1000, nd_cyc = 0, done_cyc = 0, nd_gap = 0, done_gap = 0;
  logic prev_nd = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    tests++;
    if (got < lo || got > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  // ---------------- motor model ----------------
  logic [20:0] pos = '0;
  int dly = 0;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (model_busy) begin
      busy_cnt--;
      if (busy_cnt == 0) model_busy = 1'b0;
    end
    if (dly != 0) begin
      dly--;
      if (dly == 0) begin
        model_busy = 1'b1;
        busy_cnt   = 50;
      end
    end
    if (bus.new_data && bus.data_out[TARGET_MSB:0] != pos) begin
      pos = bus.data_out[TARGET_MSB:0];
      dly = 2;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    #1;
    if (bus.new_data) begin
      issue_cnt++;
      nd_cyc = cyc;
      nd_gap = cyc - last_high;
      check("nd_single_cycle", prev_nd, 1'b0);
      check("nd_in_reset", rst_n, 1'b1);
      check_range("issue_after_busy_low", nd_gap, 2, 1000000);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_issue: got 0x%08h expected none", bus.data_out);
      end else begin
        check("issue_data", bus.data_out, exp_q.pop_front());
      end
    end
    if (bus.cmd_done) begin
      done_cnt++;
      done_cyc = cyc;
      done_gap = cyc - last_high;
    end
    if (bus.motor_busy) last_high = cyc;
    prev_nd = bus.new_data;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_dones(input int n, input int budget, input string name);
    int start = done_cnt;
    int k = 0;
    while (done_cnt < start + n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, done_cnt - start, n);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data_out"}, bus.data_out, 32'h0);
    check({tag, "_new_data"}, bus.new_data, 1'b0);
    check({tag, "_full"},     bus.full, 1'b0);
    check({tag, "_empty"},    bus.empty, 1'b1);
    check({tag, "_level"},    32'(bus.level), 32'd0);
    check({tag, "_overflow"}, bus.overflow, 1'b0);
    check({tag, "_seq_busy"}, bus.seq_busy, 1'b0);
    check({tag, "_cmd_done"}, bus.cmd_done, 1'b0);
    check({tag, "_state"},    32'(state_dbg), 32'(ST_IDLE));
  endtask

  function automatic logic [31:0] mk_cmd(input int target, input int dwell_ms);
    logic [31:0] c;
    c = 32'h0;
    c[TARGET_MSB:0] = 21'(target);
    c[DWELL_MSB:DWELL_LSB] = 10'(dwell_ms);
    return c;
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    int wr_cyc, base_issue, base_done, k;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.clr_ovf = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Single command: target 100, dwell 1 ms.
    bus.wr_en = 1'b1;
    bus.wr_data = 32'h0020_0064;
    exp_q.push_back(32'h0020_0064);
    wr_cyc = cyc;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("t1_visible", bus.empty, 1'b0);
    wait_dones(1, 200, "t1_done");
    check("t1_issue_latency", nd_cyc - wr_cyc, 2);
    check_range("t1_dwell_gap", done_gap, 10, 12);
    check("t1_data_held", bus.data_out, 32'h0020_0064);

    // Back-to-back: three dwell-0 commands queued behind a busy motor.
    base_issue = issue_cnt;
    hold_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = mk_cmd(10 * (i + 1), 0);
      exp_q.push_back(mk_cmd(10 * (i + 1), 0));
      @(negedge clk);
      check($sformatf("t2_level_%0d", i + 1), 32'(bus.level), i + 1);
    end
    bus.wr_en = 1'b0;
    hold_busy = 1'b0;
    wait_dones(3, 600, "t2_done");
    check("t2_issues", issue_cnt - base_issue, 3);
    check("t2_level_drained", 32'(bus.level), 32'd0);
    check("t2_empty", bus.empty, 1'b1);

    // Zero-length move: target equals current model position (30).
    bus.wr_en = 1'b1;
    bus.wr_data = mk_cmd(30, 0);
    exp_q.push_back(mk_cmd(30, 0));
    @(negedge clk);
    bus.wr_en = 1'b0;
    wait_dones(1, 100, "t3_done");
    check("t3_timeout_latency", done_cyc - nd_cyc, STO + 1);

    // Overflow with the motor held busy.
    base_issue = issue_cnt;
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = mk_cmd(1000 + i, 0);
      if (i < 4) exp_q.push_back(mk_cmd(1000 + i, 0));
      @(negedge clk);
      if (i == 3) begin
        check("t4_full", bus.full, 1'b1);
        check("t4_level4", 32'(bus.level), 32'd4);
        check("t4_no_ovf_yet", bus.overflow, 1'b0);
      end
    end
    bus.wr_en = 1'b0;
    check("t4_overflow", bus.overflow, 1'b1);
    check("t4_level_after_drop", 32'(bus.level), 32'd4);
    repeat (5) @(negedge clk);
    check("t4_overflow_sticky", bus.overflow, 1'b1);
    bus.wr_en = 1'b1;
    bus.clr_ovf = 1'b1;
    bus.wr_data = mk_cmd(1999, 0);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.clr_ovf = 1'b0;
    check("t4_set_wins", bus.overflow, 1'b1);
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    check("t4_cleared", bus.overflow, 1'b0);
    hold_busy = 1'b0;
    wait_dones(4, 800, "t4_done");
    check("t4_issues", issue_cnt - base_issue, 4);
    check("t4_queue_drained", exp_q.size(), 0);

    // Reset mid-DWELL with two commands still queued.
    bus.wr_en = 1'b1;
    bus.wr_data = mk_cmd(500, 5);
    exp_q.push_back(mk_cmd(500, 5));
    @(negedge clk);
    bus.wr_data = mk_cmd(600, 0);
    @(negedge clk);
    bus.wr_data = mk_cmd(601, 0);
    @(negedge clk);
    bus.wr_en = 1'b0;
    k = 0;
    while (state_dbg != ST_DWELL && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t5_reach_dwell", 32'(state_dbg), 32'(ST_DWELL));
    check("t5_level_before", 32'(bus.level), 32'd2);
    base_issue = issue_cnt;
    base_done = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_values("t5");
    repeat (150) @(negedge clk);
    check("t5_no_issue", issue_cnt - base_issue, 0);
    check("t5_no_done", done_cnt - base_done, 0);

    // Busy at pop: command waits in IDLE until the motor goes idle.
    base_issue = issue_cnt;
    hold_busy = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = mk_cmd(700, 0);
    exp_q.push_back(mk_cmd(700, 0));
    @(negedge clk);
    bus.wr_en = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_held", issue_cnt - base_issue, 0);
    check("t6_level", 32'(bus.level), 32'd1);
    check("t6_idle", bus.seq_busy, 1'b0);
    hold_busy = 1'b0;
    wait_dones(1, 200, "t6_done");
    check("t6_issue_gap", nd_gap, 2);
    check("t6_queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
